mod_carrega_matriz: RTL and testbench
=====================================

# mod_carrega_matriz

Serial-to-parallel matrix loader for the arithmetic coprocessor. It accepts matrix elements one at a time over a valid/ready handshake, in row-major order. It assembles them into a packed N×N matrix register and presents that register, with a valid flag, to the determinant and arithmetic modules. It is the producing end of the parallel element interface (a, b, c, d, ...) that those modules consume.

## Interface
- LARGURA, 8, element width in bits
- N_MAX, 5, largest supported matrix order (minimum 2)
- clk  input  1  system clock, all state updates on rising edge
- rst_n  input  1  asynchronous, active-low reset
- tamanho  input  3  requested order n; sampled only on the first accepted element of a load
- elem_dado  input  LARGURA  element value
- elem_valido  input  1  source offers elem_dado this cycle
- elem_pronto  output  1  loader can accept an element this cycle
- limpar  input  1  synchronous abort; discards the current load
- consumido  input  1  consumer has taken the presented matrix
- matriz  output  N_MAX*N_MAX*LARGURA  packed matrix; element k at bits [k*LARGURA +: LARGURA]
- matriz_valida  output  1  matriz holds a complete n×n matrix
- matriz_tamanho  output  3  order n of the presented matrix
- contagem  output  clog2(N_MAX*N_MAX+1)  elements accepted in the current load

## Operation
- An element is accepted on any rising edge where elem_valido=1 and elem_pronto=1.
- The state machine has three states: OCIOSO (empty), CARREGANDO (partial), CHEIA (full).
- elem_pronto = 1 in OCIOSO and CARREGANDO, 0 in CHEIA. It is decoded from the state register only, with no combinational path from inputs.
- Accept while in OCIOSO:
  - latch n from tamanho; n<2 is clamped to 2, n>N_MAX is clamped to N_MAX
  - zero every matriz slot, then write slot 0
  - contagem=1
  - next state is CARREGANDO, or CHEIA if n*n=1 (unreachable after clamping)
- Accept while in CARREGANDO: write slot contagem, then increment contagem. When the element just accepted is number n*n, the next state is CHEIA.
- Dense row-major packing: for n=2, slots 0..3 are a, b, c, d. Slots n*n..N_MAX*N_MAX-1 stay zero.
- In CHEIA: matriz_valida=1 and matriz_tamanho=n. matriz is stable.
- consumido=1 in CHEIA: next state is OCIOSO and matriz_valida=0. matriz and matriz_tamanho keep their values until the next load's first accept.
- consumido outside CHEIA is ignored.
- limpar=1 in any state takes priority over accept and consumido:
  - next state OCIOSO, contagem=0, matriz all zero, matriz_valida=0
  - the element offered in that cycle is not accepted
- Arithmetic is unsigned. Element values are stored verbatim with no range check.

## Timing
- Reset values (asynchronous, on rst_n=0): state OCIOSO, elem_pronto=1, matriz=0, matriz_valida=0, matriz_tamanho=2, contagem=0.
- Throughput is one element per cycle.
- matriz_valida rises on the same edge that accepts the final element, so it is visible in the following cycle. Load latency is n*n accepting cycles.
- elem_pronto falls in the same cycle matriz_valida rises.
- After consumido is sampled in CHEIA, elem_pronto=1 in the next cycle. The minimum turnaround between matrices is 1 idle cycle.
- If the source holds elem_valido=1 in CHEIA, nothing is accepted. Data must be held until elem_pronto returns.
- A tamanho change during CARREGANDO has no effect on the load in progress.
- rst_n asserted mid-load or in CHEIA: the block returns to reset values immediately, with no dependency on clk.

## Test plan
- 2x2 load: n=2, elements 3, 7, 2, 5 on 4 consecutive cycles, then one cycle later:
  - matriz_valida=1
  - matriz[31:0]=0x05020703, upper bits 0
  - matriz_tamanho=2
  - elem_pronto=0
- 3x3 load with gaps: n=3, elements 1..9 with elem_valido=0 on alternate cycles. matriz_valida=1 only after the 9th accept, slots 0..8 = 1..9, contagem=9.
- Back-pressure then turnaround:
  - hold elem_valido=1 with 0xAA in CHEIA for 5 cycles: no accept, matriz unchanged
  - pulse consumido: next cycle matriz_valida=0, elem_pronto=1, and 0xAA is accepted as slot 0 of a new load
- Clamping: tamanho=0 gives matriz_tamanho=2 after 4 elements. tamanho=7 gives matriz_tamanho=5 after 25 elements. Changing tamanho mid-load from 2 to 4 still completes after 4 elements.
- limpar mid-load:
  - after 2 of 4 elements, assert limpar together with elem_valido=1: the element is not accepted, contagem=0, matriz=0
  - next load of 9, 8, 7, 6 completes normally
- Asynchronous reset: drop rst_n between clock edges while in CHEIA. matriz_valida=0, matriz=0 and elem_pronto=1 before the next edge.

Source files
------------

// File: rtl/mod_carrega_matriz.sv
// Serial-to-parallel matrix loader: gathers row-major elements into a packed N x N register.
// Latency: n*n accepting cycles per matrix; matriz_valida is visible the cycle after the last accept.
// Backpressure: elem_pronto is low while a full matrix waits for consumido (decoded from state only).
//
// Ports:
//   clk, rst_n          clock and asynchronous active-low reset
//   tamanho             requested order n, sampled on the first accept of a load
//   elem_dado/valido    element offered by the source
//   elem_pronto         loader can take an element this cycle
//   limpar              synchronous abort of the current load (highest priority)
//   consumido           consumer has taken the presented matrix
//   matriz              packed matrix, element k at [k*LARGURA +: LARGURA]
//   matriz_valida       matriz holds a complete n x n matrix
//   matriz_tamanho      order of the presented matrix
//   contagem            elements accepted in the current load
module mod_carrega_matriz #(
  parameter int LARGURA = 8,
  parameter int N_MAX   = 5,
  localparam int CW     = $clog2(N_MAX * N_MAX + 1)
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [2:0]                     tamanho,
  input  logic [LARGURA-1:0]             elem_dado,
  input  logic                           elem_valido,
  output logic                           elem_pronto,
  input  logic                           limpar,
  input  logic                           consumido,
  output logic [N_MAX*N_MAX*LARGURA-1:0] matriz,
  output logic                           matriz_valida,
  output logic [2:0]                     matriz_tamanho,
  output logic [CW-1:0]                  contagem
);

  typedef enum logic [1:0] {
    OCIOSO     = 2'd0,
    CARREGANDO = 2'd1,
    CHEIA      = 2'd2
  } estado_t;

  localparam logic [2:0] N_MAX3 = 3'(N_MAX);

  estado_t                          estado_q, estado_d;
  logic [N_MAX*N_MAX*LARGURA-1:0]   matriz_q, matriz_d;
  logic [2:0]                       tam_q, tam_d;
  logic [CW-1:0]                    contagem_q, contagem_d;

  logic [2:0]    n_pedido;
  logic [CW-1:0] total_atual;
  logic [CW-1:0] total_novo;

  // Ready depends on the state register alone, so the source never sees a
  // combinational path from its own valid back to ready.
  assign elem_pronto    = (estado_q != CHEIA);
  assign matriz_valida  = (estado_q == CHEIA);
  assign matriz         = matriz_q;
  assign matriz_tamanho = tam_q;
  assign contagem       = contagem_q;

  always_comb begin
    // Order is only meaningful between 2 and N_MAX; out-of-range requests saturate.
    if (tamanho < 3'd2) begin
      n_pedido = 3'd2;
    end else if (tamanho > N_MAX3) begin
      n_pedido = N_MAX3;
    end else begin
      n_pedido = tamanho;
    end
    total_atual = CW'(tam_q) * CW'(tam_q);
    total_novo  = CW'(n_pedido) * CW'(n_pedido);
  end

  always_comb begin
    estado_d   = estado_q;
    matriz_d   = matriz_q;
    tam_d      = tam_q;
    contagem_d = contagem_q;

    if (limpar) begin
      estado_d   = OCIOSO;
      contagem_d = '0;
      matriz_d   = '0;
    end else begin
      case (estado_q)
        OCIOSO: begin
          if (elem_valido) begin
            // New load: the previous matrix is wiped so unused slots read zero.
            tam_d                  = n_pedido;
            matriz_d               = '0;
            matriz_d[LARGURA-1:0]  = elem_dado;
            contagem_d             = CW'(1);
            estado_d               = (total_novo == CW'(1)) ? CHEIA : CARREGANDO;
          end
        end
        CARREGANDO: begin
          if (elem_valido) begin
            matriz_d[int'(contagem_q) * LARGURA +: LARGURA] = elem_dado;
            contagem_d = contagem_q + CW'(1);
            if (contagem_d == total_atual) begin
              estado_d = CHEIA;
            end
          end
        end
        CHEIA: begin
          // Matrix and order stay visible after hand-off until the next load starts.
          if (consumido) begin
            estado_d   = OCIOSO;
            contagem_d = '0;
          end
        end
        default: begin
          estado_d = OCIOSO;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      estado_q   <= OCIOSO;
      matriz_q   <= '0;
      tam_q      <= 3'd2;
      contagem_q <= '0;
    end else begin
      estado_q   <= estado_d;
      matriz_q   <= matriz_d;
      tam_q      <= tam_d;
      contagem_q <= contagem_d;
    end
  end

endmodule

// File: tb/tb_mod_carrega_matriz.sv
module tb_mod_carrega_matriz;

  localparam int W  = 8;
  localparam int NM = 5;
  localparam int MW = NM * NM * W;
  localparam int CW = $clog2(NM * NM + 1);

  logic          clk;
  logic          rst_n;
  logic [2:0]    tamanho;
  logic [W-1:0]  elem_dado;
  logic          elem_valido;
  logic          elem_pronto;
  logic          limpar;
  logic          consumido;
  logic [MW-1:0] matriz;
  logic          matriz_valida;
  logic [2:0]    matriz_tamanho;
  logic [CW-1:0] contagem;

  int tests_run    = 0;
  int tests_failed = 0;

  typedef struct {
    logic [MW-1:0] m;
    logic [2:0]    n;
  } exp_t;

  exp_t sb[$];

  mod_carrega_matriz #(.LARGURA(W), .N_MAX(NM)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .tamanho        (tamanho),
    .elem_dado      (elem_dado),
    .elem_valido    (elem_valido),
    .elem_pronto    (elem_pronto),
    .limpar         (limpar),
    .consumido      (consumido),
    .matriz         (matriz),
    .matriz_valida  (matriz_valida),
    .matriz_tamanho (matriz_tamanho),
    .contagem       (contagem)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected matrix: first cnt values packed densely, everything above is zero.
  task automatic push_exp(input logic [2:0] n, input int cnt, input logic [7:0] vals [25]);
    exp_t e;
    e.m = '0;
    e.n = n;
    for (int k = 0; k < cnt; k++) e.m[k*W +: W] = vals[k];
    sb.push_back(e);
  endtask

  // Offers one element and returns #1 after the edge that took it.
  task automatic send(input logic [7:0] d, output bit ok);
    ok = 1'b0;
    elem_dado   = d;
    elem_valido = 1'b1;
    for (int i = 0; i < 100; i++) begin
      if (elem_pronto === 1'b1) ok = 1'b1;
      @(posedge clk); #1;
      if (ok) break;
    end
    elem_valido = 1'b0;
    if (!ok) $display("FAIL send_timeout: element %h never accepted", d);
  endtask

  task automatic consume();
    consumido = 1'b1;
    @(posedge clk); #1;
    consumido = 1'b0;
  endtask

  task automatic check_pop(input string nome);
    exp_t e;
    tests_run++;
    if (sb.size() == 0) begin
      tests_failed++;
      $display("FAIL %s_sb: scoreboard empty, expected 1 entry", nome);
    end else begin
      e = sb.pop_front();
      tests_run++;
      if (matriz_valida !== 1'b1) begin
        tests_failed++;
        $display("FAIL %s_valida: got %b want 1", nome, matriz_valida);
      end
      tests_run++;
      if (matriz !== e.m) begin
        tests_failed++;
        $display("FAIL %s_matriz: got %h want %h", nome, matriz, e.m);
      end
      tests_run++;
      if (matriz_tamanho !== e.n) begin
        tests_failed++;
        $display("FAIL %s_tamanho: got %0d want %0d", nome, matriz_tamanho, e.n);
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; tamanho = 3'd2; elem_dado = '0; elem_valido = 1'b0;
    limpar = 1'b0; consumido = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    tests_run++;
    if (elem_pronto !== 1'b1) begin tests_failed++; $display("FAIL reset_pronto: got %b want 1", elem_pronto); end
    tests_run++;
    if (matriz !== '0) begin tests_failed++; $display("FAIL reset_matriz: got %h want 0", matriz); end
    tests_run++;
    if (matriz_valida !== 1'b0) begin tests_failed++; $display("FAIL reset_valida: got %b want 0", matriz_valida); end
    tests_run++;
    if (matriz_tamanho !== 3'd2) begin tests_failed++; $display("FAIL reset_tamanho: got %0d want 2", matriz_tamanho); end
    tests_run++;
    if (contagem !== '0) begin tests_failed++; $display("FAIL reset_contagem: got %0d want 0", contagem); end
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_2x2();
    logic [7:0] v [25];
    bit ok;
    logic [31:0] baixo;
    v = '{default: 8'h00};
    v[0] = 8'd3; v[1] = 8'd7; v[2] = 8'd2; v[3] = 8'd5;
    tamanho = 3'd2;
    push_exp(3'd2, 4, v);
    for (int k = 0; k < 4; k++) begin
      send(v[k], ok);
      if (k < 3) begin
        tests_run++;
        if (matriz_valida !== 1'b0) begin tests_failed++; $display("FAIL 2x2_early_valida: elem %0d got %b want 0", k, matriz_valida); end
      end
    end
    check_pop("2x2");
    baixo = matriz[31:0];
    tests_run++;
    if (baixo !== 32'h05020703) begin tests_failed++; $display("FAIL 2x2_word: got %h want 05020703", baixo); end
    tests_run++;
    if (elem_pronto !== 1'b0) begin tests_failed++; $display("FAIL 2x2_pronto: got %b want 0", elem_pronto); end
    consume();
    tests_run++;
    if (matriz_valida !== 1'b0 || elem_pronto !== 1'b1) begin
      tests_failed++; $display("FAIL 2x2_consume: valida %b pronto %b want 0 1", matriz_valida, elem_pronto);
    end
    tests_run++;
    if (matriz[31:0] !== 32'h05020703 || matriz_tamanho !== 3'd2) begin
      tests_failed++; $display("FAIL 2x2_hold: matriz %h tamanho %0d want 05020703 2", matriz[31:0], matriz_tamanho);
    end
  endtask

  task automatic test_gaps_3x3();
    logic [7:0] v [25];
    bit ok;
    v = '{default: 8'h00};
    for (int k = 0; k < 9; k++) v[k] = 8'(k + 1);
    tamanho = 3'd3;
    push_exp(3'd3, 9, v);
    for (int k = 0; k < 9; k++) begin
      send(v[k], ok);
      if (k < 8) begin
        tests_run++;
        if (matriz_valida !== 1'b0) begin tests_failed++; $display("FAIL 3x3_early_valida: elem %0d got %b want 0", k, matriz_valida); end
        @(posedge clk); #1;
      end
    end
    check_pop("3x3");
    tests_run++;
    if (contagem !== CW'(9)) begin tests_failed++; $display("FAIL 3x3_contagem: got %0d want 9", contagem); end
  endtask

  task automatic test_back_to_back();
    logic [MW-1:0] guardada;
    logic [MW-1:0] esperado;
    guardada = '0;
    for (int k = 0; k < 9; k++) guardada[k*W +: W] = 8'(k + 1);
    elem_dado = 8'hAA; elem_valido = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    tests_run++;
    if (elem_pronto !== 1'b0 || contagem !== CW'(9)) begin
      tests_failed++; $display("FAIL bp_hold: pronto %b contagem %0d want 0 9", elem_pronto, contagem);
    end
    tests_run++;
    if (matriz !== guardada) begin tests_failed++; $display("FAIL bp_matriz: got %h want %h", matriz, guardada); end
    consumido = 1'b1;
    @(posedge clk); #1;
    consumido = 1'b0;
    tests_run++;
    if (matriz_valida !== 1'b0 || elem_pronto !== 1'b1) begin
      tests_failed++; $display("FAIL bp_turn: valida %b pronto %b want 0 1", matriz_valida, elem_pronto);
    end
    @(posedge clk); #1;
    elem_valido = 1'b0;
    esperado = '0;
    esperado[7:0] = 8'hAA;
    tests_run++;
    if (contagem !== CW'(1) || matriz !== esperado) begin
      tests_failed++; $display("FAIL bp_new_load: contagem %0d matriz %h want 1 %h", contagem, matriz, esperado);
    end
    limpar = 1'b1;
    @(posedge clk); #1;
    limpar = 1'b0;
  endtask

  task automatic test_clamp();
    logic [7:0] v [25];
    bit ok;
    v = '{default: 8'h00};
    for (int k = 0; k < 4; k++) v[k] = 8'(8'h10 + k);
    tamanho = 3'd0;
    push_exp(3'd2, 4, v);
    for (int k = 0; k < 4; k++) send(v[k], ok);
    check_pop("clamp_lo");
    consume();
    @(posedge clk); #1;

    for (int k = 0; k < 25; k++) v[k] = 8'(k * 3 + 1);
    tamanho = 3'd7;
    push_exp(3'd5, 25, v);
    for (int k = 0; k < 25; k++) begin
      send(v[k], ok);
      if (k == 3) begin
        tests_run++;
        if (matriz_valida !== 1'b0) begin tests_failed++; $display("FAIL clamp_hi_early: got %b want 0", matriz_valida); end
      end
    end
    check_pop("clamp_hi");
    consume();

    v = '{default: 8'h00};
    v[0] = 8'h21; v[1] = 8'h42; v[2] = 8'h63; v[3] = 8'h84;
    tamanho = 3'd2;
    push_exp(3'd2, 4, v);
    send(v[0], ok);
    send(v[1], ok);
    tamanho = 3'd4;
    send(v[2], ok);
    send(v[3], ok);
    check_pop("midchange");
    consume();
  endtask

  task automatic test_limpar();
    logic [7:0] v [25];
    bit ok;
    tamanho = 3'd2;
    send(8'h11, ok);
    send(8'h22, ok);
    limpar = 1'b1; elem_valido = 1'b1; elem_dado = 8'h33;
    @(posedge clk); #1;
    limpar = 1'b0; elem_valido = 1'b0;
    tests_run++;
    if (contagem !== '0) begin tests_failed++; $display("FAIL limpar_contagem: got %0d want 0", contagem); end
    tests_run++;
    if (matriz !== '0) begin tests_failed++; $display("FAIL limpar_matriz: got %h want 0", matriz); end
    tests_run++;
    if (matriz_valida !== 1'b0 || elem_pronto !== 1'b1) begin
      tests_failed++; $display("FAIL limpar_flags: valida %b pronto %b want 0 1", matriz_valida, elem_pronto);
    end
    v = '{default: 8'h00};
    v[0] = 8'd9; v[1] = 8'd8; v[2] = 8'd7; v[3] = 8'd6;
    push_exp(3'd2, 4, v);
    for (int k = 0; k < 4; k++) send(v[k], ok);
    check_pop("after_limpar");
  endtask

  task automatic test_async_reset();
    tests_run++;
    if (matriz_valida !== 1'b1) begin tests_failed++; $display("FAIL areset_pre: valida %b want 1", matriz_valida); end
    #2;
    rst_n = 1'b0;
    #1;
    tests_run++;
    if (matriz_valida !== 1'b0) begin tests_failed++; $display("FAIL areset_valida: got %b want 0", matriz_valida); end
    tests_run++;
    if (matriz !== '0) begin tests_failed++; $display("FAIL areset_matriz: got %h want 0", matriz); end
    tests_run++;
    if (elem_pronto !== 1'b1 || contagem !== '0) begin
      tests_failed++; $display("FAIL areset_pronto: pronto %b contagem %0d want 1 0", elem_pronto, contagem);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  initial begin
    test_reset();
    test_2x2();
    test_gaps_3x3();
    test_back_to_back();
    test_clamp();
    test_limpar();
    test_async_reset();
    tests_run++;
    if (sb.size() != 0) begin tests_failed++; $display("FAIL sb_leftover: %0d entries want 0", sb.size()); end
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
